// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer: state encoding,
// default phase durations (in clk190 ticks) and default timer width.
package wm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FILL  = 4'd1,
        ST_WASH  = 4'd2,
        ST_DRAIN = 4'd3,
        ST_SPIN  = 4'd4,
        ST_DONE  = 4'd5,
        ST_PAUSE = 4'd6,
        ST_FAULT = 4'd7
    } state_t;

    localparam int unsigned DEF_FILL_TICKS  = 3800;
    localparam int unsigned DEF_WASH_TICKS  = 11400;
    localparam int unsigned DEF_RINSE_TICKS = 5700;
    localparam int unsigned DEF_DRAIN_TICKS = 3800;
    localparam int unsigned DEF_SPIN_TICKS  = 5700;
    localparam int unsigned DEF_AGIT_TICKS  = 380;
    localparam int unsigned DEF_CNT_W       = 16;

    // States whose duration or timeout is governed by the phase timer.
    function automatic logic is_timed(input state_t s);
        return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) || (s == ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_cycle_ctrl_phase_timer.sv
// Loadable down-counter for phase durations. Holds at zero; load wins over
// count enable. zero_o is high whenever the count reads zero.
module phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk190,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: load, else decrement while enabled and non-zero.
    always_ff @(posedge clk190 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine main sequencer on the clk190 domain.
// Sequence: fill -> wash -> drain -> rinse fill -> rinse -> drain -> spin.
// Optional drum-direction agitation during WASH: define WASH_AGITATE_EN.
module wash_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned FILL_TICKS  = DEF_FILL_TICKS,
    parameter int unsigned WASH_TICKS  = DEF_WASH_TICKS,
    parameter int unsigned RINSE_TICKS = DEF_RINSE_TICKS,
    parameter int unsigned DRAIN_TICKS = DEF_DRAIN_TICKS,
    parameter int unsigned SPIN_TICKS  = DEF_SPIN_TICKS,
    parameter int unsigned AGIT_TICKS  = DEF_AGIT_TICKS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic       clk190,
    input  logic       rst,
    input  logic       start_p,
    input  logic       pause_p,
    input  logic       cancel_p,
    input  logic       lid_closed,
    input  logic       water_full,
    input  logic       water_empty,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       motor_fast,
    output logic       motor_dir,
    output logic       door_lock,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_TICKS - 1);
    localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_TICKS - 1);

    state_t           state_q, state_d;
    state_t           saved_q, saved_d;
    logic             rinse_q, rinse_d;
    logic             cancel_q, cancel_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_zero;
    logic             hold_evt;
    logic             dir_out_d;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk190     (clk190),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    assign hold_evt = pause_p || !lid_closed;

    // The timer only counts while the machine stays in the same timed state,
    // so the cycle that leaves for PAUSE does not consume a tick.
    assign tmr_en = (state_d == state_q) && is_timed(state_q);

    // State, flag and phase registers.
    always_ff @(posedge clk190 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            saved_q  <= ST_IDLE;
            rinse_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            rinse_q  <= rinse_d;
            cancel_q <= cancel_d;
        end
    end

    // Next-state logic; priority is cancel, then lid/pause, then sensor/timer.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        rinse_d  = rinse_q;
        cancel_d = cancel_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_p && lid_closed) begin
                    state_d  = ST_FILL;
                    rinse_d  = 1'b0;
                    cancel_d = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = FILL_LD;
                end
            end
            ST_FILL, ST_WASH, ST_SPIN: begin
                if (cancel_p) begin
                    state_d  = ST_DRAIN;
                    cancel_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LD;
                end else if (hold_evt) begin
                    state_d = ST_PAUSE;
                    saved_d = state_q;
                end else if (state_q == ST_FILL) begin
                    if (water_full) begin
                        state_d  = ST_WASH;
                        tmr_load = 1'b1;
                        tmr_val  = rinse_q ? RINSE_LD : WASH_LD;
                    end else if (tmr_zero) begin
                        state_d = ST_FAULT;
                    end
                end else if (tmr_zero) begin
                    if (state_q == ST_WASH) begin
                        state_d  = ST_DRAIN;
                        tmr_load = 1'b1;
                        tmr_val  = DRAIN_LD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (cancel_p) begin
                    cancel_d = 1'b1;
                end else if (hold_evt) begin
                    state_d = ST_PAUSE;
                    saved_d = ST_DRAIN;
                end else if (water_empty) begin
                    if (cancel_q) begin
                        state_d  = ST_IDLE;
                        cancel_d = 1'b0;
                    end else if (!rinse_q) begin
                        state_d  = ST_FILL;
                        rinse_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = FILL_LD;
                    end else begin
                        state_d  = ST_SPIN;
                        tmr_load = 1'b1;
                        tmr_val  = SPIN_LD;
                    end
                end else if (tmr_zero) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE: begin
                if (start_p || cancel_p) begin
                    state_d  = ST_IDLE;
                    cancel_d = 1'b0;
                end
            end
            ST_PAUSE: begin
                if (cancel_p) begin
                    state_d  = ST_DRAIN;
                    cancel_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LD;
                end else if (pause_p && lid_closed) begin
                    state_d = saved_q;
                end
            end
            ST_FAULT: begin
                if (cancel_p) begin
                    state_d  = ST_IDLE;
                    cancel_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef WASH_AGITATE_EN
    logic [CNT_W-1:0] agit_cnt_q, agit_cnt_d;
    logic             agit_dir_q, agit_dir_d;

    // Agitation counter/direction registers.
    always_ff @(posedge clk190 or posedge rst) begin
        if (rst) begin
            agit_cnt_q <= '0;
            agit_dir_q <= 1'b0;
        end else begin
            agit_cnt_q <= agit_cnt_d;
            agit_dir_q <= agit_dir_d;
        end
    end

    // Fresh WASH entry restarts agitation; resume from PAUSE keeps it.
    always_comb begin
        agit_cnt_d = agit_cnt_q;
        agit_dir_d = agit_dir_q;
        if ((state_d == ST_WASH) && (state_q != ST_WASH) && (state_q != ST_PAUSE)) begin
            agit_cnt_d = '0;
            agit_dir_d = 1'b0;
        end else if ((state_q == ST_WASH) && (state_d == ST_WASH)) begin
            if (agit_cnt_q == CNT_W'(AGIT_TICKS - 1)) begin
                agit_cnt_d = '0;
                agit_dir_d = ~agit_dir_q;
            end else begin
                agit_cnt_d = agit_cnt_q + 1'b1;
            end
        end
        dir_out_d = (state_d == ST_WASH) ? agit_dir_d : 1'b0;
    end
`else
    assign dir_out_d = 1'b0;
`endif

    // Registered actuator and status outputs decoded from the next state.
    always_ff @(posedge clk190 or posedge rst) begin
        if (rst) begin
            fill_valve  <= 1'b0;
            drain_valve <= 1'b0;
            motor_on    <= 1'b0;
            motor_fast  <= 1'b0;
            motor_dir   <= 1'b0;
            door_lock   <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            fill_valve  <= (state_d == ST_FILL);
            drain_valve <= (state_d == ST_DRAIN) || (state_d == ST_SPIN);
            motor_on    <= (state_d == ST_WASH) || (state_d == ST_SPIN);
            motor_fast  <= (state_d == ST_SPIN);
            motor_dir   <= dir_out_d;
            door_lock   <= is_timed(state_d) || (state_d == ST_PAUSE);
            done        <= (state_d == ST_DONE);
            fault       <= (state_d == ST_FAULT);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl with shortened phase durations.
module tb_wash_cycle_ctrl;

    logic       clk190 = 1'b0;
    logic       rst = 1'b1;
    logic       start_p = 1'b0, pause_p = 1'b0, cancel_p = 1'b0;
    logic       lid_closed = 1'b1, water_full = 1'b0, water_empty = 1'b0;
    logic       fill_valve, drain_valve, motor_on, motor_fast, motor_dir;
    logic       door_lock, done, fault;
    logic [3:0] state_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Expected output vectors: {fill, drain, motor_on, fast, dir, lock, done, fault}
    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_FILL  = 8'b1000_0100;
    localparam logic [7:0] O_WASH  = 8'b0010_0100;
    localparam logic [7:0] O_DRAIN = 8'b0100_0100;
    localparam logic [7:0] O_SPIN  = 8'b0111_0100;
    localparam logic [7:0] O_DONE  = 8'b0000_0010;
    localparam logic [7:0] O_PAUSE = 8'b0000_0100;
    localparam logic [7:0] O_FAULT = 8'b0000_0001;

    localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_WASH = 4'd2, S_DRAIN = 4'd3;
    localparam logic [3:0] S_SPIN = 4'd4, S_DONE = 4'd5, S_PAUSE = 4'd6, S_FAULT = 4'd7;

    wash_cycle_ctrl #(
        .FILL_TICKS  (5),
        .WASH_TICKS  (10),
        .RINSE_TICKS (6),
        .DRAIN_TICKS (5),
        .SPIN_TICKS  (8),
        .AGIT_TICKS  (3),
        .CNT_W       (16)
    ) dut (
        .clk190      (clk190),
        .rst         (rst),
        .start_p     (start_p),
        .pause_p     (pause_p),
        .cancel_p    (cancel_p),
        .lid_closed  (lid_closed),
        .water_full  (water_full),
        .water_empty (water_empty),
        .fill_valve  (fill_valve),
        .drain_valve (drain_valve),
        .motor_on    (motor_on),
        .motor_fast  (motor_fast),
        .motor_dir   (motor_dir),
        .door_lock   (door_lock),
        .done        (done),
        .fault       (fault),
        .state_o     (state_o)
    );

    always #5 clk190 = ~clk190;

    // in = {start, pause, cancel, lid, full, empty}
    typedef struct {
        string      nm;
        logic [5:0] in;
        int         n;
        logic [3:0] st;
        logic [7:0] out;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input int cyc, input logic [3:0] es, input logic [7:0] eo);
        logic [7:0] got;
        got = {fill_valve, drain_valve, motor_on, motor_fast, motor_dir, door_lock, done, fault};
        checks++;
        if (state_o !== es || got !== eo) begin
            errors++;
            $display("FAIL %s cyc%0d: got state=%0d out=%b, expected state=%0d out=%b",
                     nm, cyc, state_o, got, es, eo);
        end
    endtask

    // Drive inputs, then check after each of n clock edges.
    task automatic step(input string nm, input logic [5:0] in, input int n,
                        input logic [3:0] es, input logic [7:0] eo);
        {start_p, pause_p, cancel_p, lid_closed, water_full, water_empty} = in;
        for (int i = 0; i < n; i++) begin
            @(posedge clk190);
            #1;
            chk(nm, i, es, eo);
        end
    endtask

    initial begin
        tbl[0]  = '{"t1_start",     6'b100100, 1, S_FILL,  O_FILL};
        tbl[1]  = '{"t1_fill",      6'b000100, 2, S_FILL,  O_FILL};
        tbl[2]  = '{"t1_full",      6'b000110, 1, S_WASH,  O_WASH};
        tbl[3]  = '{"t1_wash",      6'b000110, 9, S_WASH,  O_WASH};
        tbl[4]  = '{"t1_wash_end",  6'b000110, 1, S_DRAIN, O_DRAIN};
        tbl[5]  = '{"t1_drain",     6'b000100, 1, S_DRAIN, O_DRAIN};
        tbl[6]  = '{"t1_empty",     6'b000101, 1, S_FILL,  O_FILL};
        tbl[7]  = '{"t1_rfill",     6'b000100, 2, S_FILL,  O_FILL};
        tbl[8]  = '{"t1_rfull",     6'b000110, 1, S_WASH,  O_WASH};
        tbl[9]  = '{"t1_rinse",     6'b000110, 5, S_WASH,  O_WASH};
        tbl[10] = '{"t1_rinse_end", 6'b000110, 1, S_DRAIN, O_DRAIN};
        tbl[11] = '{"t1_rdrain",    6'b000100, 1, S_DRAIN, O_DRAIN};
        tbl[12] = '{"t1_rempty",    6'b000101, 1, S_SPIN,  O_SPIN};
        tbl[13] = '{"t1_spin",      6'b000101, 7, S_SPIN,  O_SPIN};
        tbl[14] = '{"t1_spin_end",  6'b000101, 1, S_DONE,  O_DONE};
        tbl[15] = '{"t1_done",      6'b000100, 2, S_DONE,  O_DONE};
        tbl[16] = '{"t1_done_start",6'b100100, 1, S_IDLE,  O_IDLE};

        // Reset state
        #12;
        chk("reset", 0, S_IDLE, O_IDLE);
        @(negedge clk190);
        rst = 1'b0;
        step("idle_hold", 6'b000100, 2, S_IDLE, O_IDLE);

        // Full cycle
        foreach (tbl[k]) step(tbl[k].nm, tbl[k].in, tbl[k].n, tbl[k].st, tbl[k].out);

        // Pause mid-wash, resume with frozen timer
        step("t2_start",     6'b100100, 1,  S_FILL,  O_FILL);
        step("t2_full",      6'b000110, 1,  S_WASH,  O_WASH);
        step("t2_wash",      6'b000100, 4,  S_WASH,  O_WASH);
        step("t2_pause",     6'b010100, 1,  S_PAUSE, O_PAUSE);
        step("t2_paused",    6'b000100, 20, S_PAUSE, O_PAUSE);
        step("t2_resume",    6'b010100, 1,  S_WASH,  O_WASH);
        step("t2_wash_rest", 6'b000100, 5,  S_WASH,  O_WASH);
        step("t2_wash_end",  6'b000100, 1,  S_DRAIN, O_DRAIN);
        step("t2_empty",     6'b000101, 1,  S_FILL,  O_FILL);
        step("t2_rfull",     6'b000110, 1,  S_WASH,  O_WASH);
        step("t2_rinse",     6'b000100, 5,  S_WASH,  O_WASH);
        step("t2_rinse_end", 6'b000100, 1,  S_DRAIN, O_DRAIN);
        step("t2_rempty",    6'b000101, 1,  S_SPIN,  O_SPIN);

        // Lid opens in spin
        step("t3_spin",      6'b000101, 2, S_SPIN,  O_SPIN);
        step("t3_lid_open",  6'b000001, 1, S_PAUSE, O_PAUSE);
        step("t3_pause_open",6'b010001, 1, S_PAUSE, O_PAUSE);
        step("t3_lid_close", 6'b000101, 1, S_PAUSE, O_PAUSE);
        step("t3_resume",    6'b010101, 1, S_SPIN,  O_SPIN);
        step("t3_spin_rest", 6'b000101, 5, S_SPIN,  O_SPIN);
        step("t3_spin_end",  6'b000101, 1, S_DONE,  O_DONE);
        step("t3_cancel",    6'b001100, 1, S_IDLE,  O_IDLE);

        // Cancel beats pause; cancelled drain returns to idle
        step("t4_lid_open_start", 6'b100000, 1, S_IDLE, O_IDLE);
        step("t4_start",     6'b100100, 1, S_FILL,  O_FILL);
        step("t4_full",      6'b000110, 1, S_WASH,  O_WASH);
        step("t4_wash",      6'b000100, 2, S_WASH,  O_WASH);
        step("t4_cancel",    6'b011100, 1, S_DRAIN, O_DRAIN);
        step("t4_drain",     6'b000100, 1, S_DRAIN, O_DRAIN);
        step("t4_empty",     6'b000101, 1, S_IDLE,  O_IDLE);

        // Fill timeout
        step("t5_start",     6'b100100, 1, S_FILL,  O_FILL);
        step("t5_fill",      6'b000100, 4, S_FILL,  O_FILL);
        step("t5_timeout",   6'b000100, 1, S_FAULT, O_FAULT);
        step("t5_start_ign", 6'b100100, 1, S_FAULT, O_FAULT);
        step("t5_pause_ign", 6'b010100, 1, S_FAULT, O_FAULT);
        step("t5_cancel",    6'b001100, 1, S_IDLE,  O_IDLE);

        // Asynchronous reset mid-spin, then fresh cycle with full wash length
        step("t6_start",     6'b100100, 1, S_FILL,  O_FILL);
        step("t6_full",      6'b000110, 1, S_WASH,  O_WASH);
        step("t6_wash",      6'b000100, 9, S_WASH,  O_WASH);
        step("t6_wash_end",  6'b000100, 1, S_DRAIN, O_DRAIN);
        step("t6_empty",     6'b000101, 1, S_FILL,  O_FILL);
        step("t6_rfull",     6'b000110, 1, S_WASH,  O_WASH);
        step("t6_rinse",     6'b000100, 5, S_WASH,  O_WASH);
        step("t6_rinse_end", 6'b000100, 1, S_DRAIN, O_DRAIN);
        step("t6_rempty",    6'b000101, 1, S_SPIN,  O_SPIN);
        step("t6_spin",      6'b000101, 3, S_SPIN,  O_SPIN);
        #1 rst = 1'b1;
        #1 chk("t6_async_rst", 0, S_IDLE, O_IDLE);
        @(negedge clk190);
        rst = 1'b0;
        step("t6_post_idle", 6'b000100, 1, S_IDLE,  O_IDLE);
        step("t6_restart",   6'b100100, 1, S_FILL,  O_FILL);
        step("t6_refull",    6'b000110, 1, S_WASH,  O_WASH);
        step("t6_rewash",    6'b000100, 9, S_WASH,  O_WASH);
        step("t6_rewash_end",6'b000100, 1, S_DRAIN, O_DRAIN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
